// File: rtl/pam4_tx_pkg.sv
// Shared constants for the PAM4 VCO-emulation transmitter: symbol codes,
// per-symbol NCO frequency control words, FSM state encoding and PRBS7 helpers.
package pam4_tx_pkg;

    localparam int unsigned PH_W  = 24;
    localparam int unsigned SYM_W = 2;

    // PAM4 level codes
    localparam logic [SYM_W-1:0] SYM_M3 = 2'b00;
    localparam logic [SYM_W-1:0] SYM_M1 = 2'b01;
    localparam logic [SYM_W-1:0] SYM_P1 = 2'b10;
    localparam logic [SYM_W-1:0] SYM_P3 = 2'b11;

    // NCO increments at 50 MHz clk: 10, 15, 20 and 25 MHz
    localparam logic [PH_W-1:0] FCW_M3 = 24'h33_3333;
    localparam logic [PH_W-1:0] FCW_M1 = 24'h4C_CCCD;
    localparam logic [PH_W-1:0] FCW_P1 = 24'h66_6666;
    localparam logic [PH_W-1:0] FCW_P3 = 24'h80_0000;

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_RUN      = 2'd2
    } tx_state_e;

    // Symbol code to NCO frequency control word
    function automatic logic [PH_W-1:0] sym_fcw(input logic [SYM_W-1:0] sym);
        logic [PH_W-1:0] fcw;
        case (sym)
            SYM_M3:  fcw = FCW_M3;
            SYM_M1:  fcw = FCW_M1;
            SYM_P1:  fcw = FCW_P1;
            default: fcw = FCW_P3;
        endcase
        return fcw;
    endfunction

    // One PRBS7 (x^7 + x^6 + 1) step; the new bit enters at bit 0
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/pam4_sym_fifo.sv
// Small synchronous FIFO for queued PAM4 symbols. Push is ignored when full,
// pop is ignored when empty; both may take effect in the same cycle.
module pam4_sym_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, no reset needed since occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pam4_vco_tx.sv
// PAM4 transmitter emulating a VCO: each symbol selects the frequency of a
// phase-continuous square wave on DATA for one UI. A fixed 00/11 preamble is
// sent before queued symbols.
// Build macro PAM4_TX_PRBS_EN: RUN symbols come from an internal PRBS7 and the
// symbol input is ignored.
module pam4_vco_tx
    import pam4_tx_pkg::*;
#(
    parameter logic [23:0] UI_FCW     = 24'h80_0000,
    parameter int unsigned PRE_UIS    = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sym_valid,
    input  logic [1:0] sym_data,
    output logic       sym_ready,
    output logic       DATA,
    output logic       ui_tick,
    output logic [1:0] cur_sym,
    output logic       underflow,
    output logic [7:0] underflow_cnt
);

    localparam int unsigned PCW = $clog2(PRE_UIS + 1);

    tx_state_e        state_q;
    logic [PH_W-1:0]  ui_ph_q;
    logic [PH_W-1:0]  ui_ph_d;
    logic [PH_W-1:0]  ui_ph_nn;
    logic [PH_W-1:0]  nco_ph_q;
    logic [PH_W-1:0]  nco_ph_d;
    logic             tick_q;
    logic             tick_d;
    logic [SYM_W-1:0] cur_sym_q;
    logic [PCW-1:0]   pre_cnt_q;
    logic             uf_q;
    logic [7:0]       uf_cnt_q;

    logic             load_c;
    logic             uf_c;
    logic             push_c;
    logic             pop_c;
    logic [SYM_W-1:0] run_sym_c;

    logic             fifo_full;
    logic             fifo_empty;
    logic [SYM_W-1:0] fifo_dout;

    // Accumulator next values; both collapse to zero when disabled
    always_comb begin
        ui_ph_d  = '0;
        nco_ph_d = '0;
        if (en) begin
            ui_ph_d = ui_ph_q + UI_FCW;
            if (state_q != ST_IDLE) begin
                nco_ph_d = nco_ph_q + sym_fcw(cur_sym_q);
            end
        end
    end

    // Tick is registered one cycle ahead: it marks the cycle whose increment wraps
    assign ui_ph_nn = ui_ph_d + UI_FCW;
    assign tick_d   = en && (ui_ph_nn < ui_ph_d);

    // A new data symbol is loaded on every RUN tick and on the tick ending the preamble
    assign load_c = tick_q && en &&
                    ((state_q == ST_RUN) ||
                     ((state_q == ST_PREAMBLE) && (pre_cnt_q == PCW'(PRE_UIS))));

`ifdef PAM4_TX_PRBS_EN
    logic [6:0] prbs_q;
    logic [6:0] prbs_mid_c;
    logic [6:0] prbs_nxt_c;
    logic       unused_prbs_inputs;

    assign prbs_mid_c = prbs7_step(prbs_q);
    assign prbs_nxt_c = prbs7_step(prbs_mid_c);
    assign run_sym_c  = {prbs_mid_c[0], prbs_nxt_c[0]};
    assign push_c     = 1'b0;
    assign pop_c      = 1'b0;
    assign uf_c       = 1'b0;
    assign sym_ready  = 1'b0;
    assign unused_prbs_inputs = ^{sym_valid, fifo_full, fifo_empty, fifo_dout};

    // PRBS restarts from the seed whenever the link is idle
    always_ff @(posedge clk) begin
        if (rst || !en || (state_q == ST_IDLE)) begin
            prbs_q <= PRBS_SEED;
        end else if (load_c) begin
            prbs_q <= prbs_nxt_c;
        end
    end
`else
    assign push_c    = sym_valid && !fifo_full;
    assign pop_c     = load_c;
    assign uf_c      = load_c && fifo_empty;
    assign run_sym_c = fifo_empty ? SYM_M1 : fifo_dout;
    assign sym_ready = !fifo_full;
`endif

    pam4_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SYM_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (sym_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Control FSM, accumulators and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ui_ph_q   <= '0;
            nco_ph_q  <= '0;
            tick_q    <= 1'b0;
            cur_sym_q <= SYM_M1;
            pre_cnt_q <= '0;
            uf_q      <= 1'b0;
            uf_cnt_q  <= '0;
        end else begin
            ui_ph_q  <= ui_ph_d;
            nco_ph_q <= nco_ph_d;
            tick_q   <= tick_d;
            uf_q     <= uf_c;
            if (uf_c && (uf_cnt_q != 8'hFF)) begin
                uf_cnt_q <= uf_cnt_q + 8'd1;
            end
            if (!en) begin
                state_q   <= ST_IDLE;
                cur_sym_q <= SYM_M1;
                pre_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_PREAMBLE;
                        pre_cnt_q <= '0;
                    end
                    ST_PREAMBLE: begin
                        if (load_c) begin
                            state_q   <= ST_RUN;
                            cur_sym_q <= run_sym_c;
                        end else if (tick_q) begin
                            cur_sym_q <= pre_cnt_q[0] ? SYM_P3 : SYM_M3;
                            pre_cnt_q <= pre_cnt_q + PCW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (load_c) begin
                            cur_sym_q <= run_sym_c;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign DATA          = nco_ph_q[PH_W-1];
    assign ui_tick       = tick_q;
    assign cur_sym       = cur_sym_q;
    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_pam4_vco_tx.sv
// Directed bench for pam4_vco_tx with default parameters. Outputs are sampled
// and inputs driven on the falling clock edge.
module tb_pam4_vco_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       DATA;
    logic       ui_tick;
    logic [1:0] cur_sym;
    logic       underflow;
    logic [7:0] underflow_cnt;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int last_tick = -1;
    int n_uf      = 0;

`ifdef PAM4_TX_PRBS_EN
    localparam bit PRBS = 1'b1;
`else
    localparam bit PRBS = 1'b0;
`endif

    // DATA right after enable: NCO adds 4CCCCD once, then 00,00,11,11,...
    logic [0:8]  start_data = 9'b001101101;
    // DATA and cur_sym in the first 11 RUN cycles (NCO phase 7FFFCD at entry)
    logic [0:10] run_data   = 11'b01100101010;
    logic [1:0]  run_sym [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd2, 2'd2, 2'd1};

    always #10 clk = ~clk;

    pam4_vco_tx dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sym_valid     (sym_valid),
        .sym_data      (sym_data),
        .sym_ready     (sym_ready),
        .DATA          (DATA),
        .ui_tick       (ui_tick),
        .cur_sym       (cur_sym),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (ui_tick !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        if (ui_tick !== 1'b1) begin
            chk("tick_seen", ui_tick, 1);
        end else if (last_tick >= 0) begin
            chk("ui_period", cyc - last_tick, 2);
        end
        last_tick = cyc;
    endtask

    task automatic run_preamble();
        for (int i = 0; i < 256; i++) begin
            wait_tick();
            step();
            chk("pre_sym", cur_sym, (i % 2 == 0) ? 2'b00 : 2'b11);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] s;
        logic       b1;
        logic       b0;

        rst = 1'b1; en = 1'b0; sym_valid = 1'b0; sym_data = 2'b00;
        @(negedge clk);
        repeat (3) step();
        chk("rst_data", DATA, 0);
        chk("rst_tick", ui_tick, 0);
        chk("rst_sym", cur_sym, 2'b01);
        chk("rst_uf", underflow, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        chk("rst_ready", sym_ready, PRBS ? 0 : 1);

        // Phase-continuous start of the preamble
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("start_data", DATA, start_data[k]);
            chk("start_tick", ui_tick, (k % 2 == 0) ? 1 : 0);
        end

        // Reset beats enable and pushes
        rst = 1'b1; sym_valid = 1'b1; sym_data = 2'b11;
        repeat (5) step();
        chk("rsto_data", DATA, 0);
        chk("rsto_tick", ui_tick, 0);
        chk("rsto_sym", cur_sym, 2'b01);
        chk("rsto_ready", sym_ready, PRBS ? 0 : 1);

        rst = 1'b0; en = 1'b0; last_tick = -1;
`ifdef PAM4_TX_PRBS_EN
        en = 1'b1;
        run_preamble();
        s = 7'h7F;
        for (int u = 0; u < 127; u++) begin
            wait_tick();
            chk("prbs_ready", sym_ready, 0);
            step();
            b1 = s[6] ^ s[5]; s = {s[5:0], b1};
            b0 = s[6] ^ s[5]; s = {s[5:0], b0};
            chk("prbs_sym", cur_sym, {b1, b0});
            chk("prbs_uf", underflow, 0);
        end
`else
        s = 7'h00; b1 = 1'b0; b0 = 1'b0;
        // Fill the FIFO while idle, keep a fifth symbol offered
        for (int k = 0; k < 4; k++) begin
            sym_data = 2'(k);
            step();
        end
        chk("fill_ready", sym_ready, 0);
        sym_data = 2'b10;
        en = 1'b1;
        run_preamble();

        // Tick ending the preamble pops while a push is offered to a full FIFO
        wait_tick();
        chk("pop_full_ready", sym_ready, 0);
        for (int k = 0; k < 11; k++) begin
            step();
            chk("run_data", DATA, run_data[k]);
            chk("run_sym", cur_sym, run_sym[k]);
            chk("run_uf", underflow, (k == 10) ? 1 : 0);
            if (k == 0) chk("after_pop_ready", sym_ready, 1);
            if (k == 1) begin
                chk("refill_ready", sym_ready, 0);
                sym_valid = 1'b0;
            end
        end
        n_uf = 1;

        // Starved RUN: one underflow per UI, counter saturates
        last_tick = -1;
        for (int u = 0; u < 299; u++) begin
            wait_tick();
            chk("uf_gap", underflow, 0);
            step();
            n_uf++;
            chk("uf_pulse", underflow, 1);
            chk("uf_sym", cur_sym, 2'b01);
            if (n_uf == 254) chk("ucnt_254", underflow_cnt, 8'hFE);
            if (n_uf == 255) chk("ucnt_255", underflow_cnt, 8'hFF);
        end
        chk("ucnt_sat", underflow_cnt, 8'hFF);

        // Push into an empty FIFO on a tick, queue a second symbol, drop enable
        wait_tick();
        sym_valid = 1'b1; sym_data = 2'b10;
        step();
        chk("uf_with_push", underflow, 1);
        sym_data = 2'b11; en = 1'b0;
        step();
        chk("idle_data", DATA, 0);
        chk("idle_tick", ui_tick, 0);
        chk("idle_sym", cur_sym, 2'b01);
        chk("idle_ready", sym_ready, 1);
        sym_valid = 1'b0;
        repeat (3) begin
            step();
            chk("idle_hold", DATA, 0);
        end

        // Re-enable: preamble again, then the two retained symbols
        en = 1'b1; last_tick = -1;
        run_preamble();
        wait_tick(); step();
        chk("resume_sym0", cur_sym, 2'b10);
        chk("resume_uf0", underflow, 0);
        wait_tick(); step();
        chk("resume_sym1", cur_sym, 2'b11);
        wait_tick(); step();
        chk("resume_empty_sym", cur_sym, 2'b01);
        chk("resume_empty_uf", underflow, 1);
        chk("resume_ucnt", underflow_cnt, 8'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pam4_vco_tx.md
PAM4_VCO_TX -- requirements
Module: pam4_vco_tx

Interface
REQ-001 SHALL have parameter UI_FCW, default 24'h80_0000; UI phase increment, giving UI = 2 clk (25 MHz at 50 MHz clk).
REQ-002 SHALL have parameter PRE_UIS, default 256; preamble length in UIs.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit; single system clock (50 MHz).
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit; transmit enable.
REQ-007 SHALL have port sym_valid, input, 1 bit; symbol offered.
REQ-008 SHALL have port sym_data, input, 2 bits; PAM4 code: 00=-3, 01=-1, 10=+1, 11=+3.
REQ-009 SHALL have port sym_ready, output, 1 bit; FIFO can accept a symbol.
REQ-010 SHALL have port DATA, output, 1 bit; frequency-coded VCO-emulation square wave.
REQ-011 SHALL have port ui_tick, output, 1 bit; 1-cycle pulse at each UI boundary.
REQ-012 SHALL have port cur_sym, output, 2 bits; symbol currently being transmitted.
REQ-013 SHALL have port underflow, output, 1 bit; 1-cycle pulse when a UI starts with the FIFO empty in RUN.
REQ-014 SHALL have port underflow_cnt, output, 8 bits; saturating count of underflow events.

Function
REQ-015 SHALL run a 24-bit UI accumulator, ui_ph <= ui_ph + UI_FCW, and assert ui_tick = 1 in any cycle where the next value is less than the current value (wrap).
REQ-016 SHALL run a 24-bit NCO accumulator, nco_ph <= nco_ph + FCW(cur_sym), with DATA = nco_ph[23], registered.
REQ-017 SHALL use FCW(00)=24'h33_3333 (10 MHz), FCW(01)=24'h4C_CCCD (15 MHz), FCW(10)=24'h66_6666 (20 MHz), FCW(11)=24'h80_0000 (25 MHz).
REQ-018 SHALL implement states IDLE, PREAMBLE and RUN.
REQ-019 In IDLE the block SHALL hold both accumulators at 0, DATA=0, cur_sym=01 and ui_tick=0.
REQ-020 The transition IDLE->PREAMBLE SHALL occur on the first cycle en=1; the UI accumulator starts counting that cycle.
REQ-021 In PREAMBLE, cur_sym SHALL alternate 00,11,00,... at each ui_tick, starting with 00, for PRE_UIS UIs, then the block SHALL enter RUN at the next ui_tick.
REQ-022 In RUN, at each ui_tick the block SHALL pop the FIFO head into cur_sym; if the FIFO is empty it SHALL set cur_sym=01 and pulse underflow.
REQ-023 en=0 in any state SHALL force IDLE on the next clk edge; the FIFO contents SHALL be retained.
REQ-024 sym_ready SHALL equal !full, where full is derived from the registered occupancy; a push occurs when sym_valid && sym_ready, in any state.
REQ-025 A push and a pop in the same cycle SHALL both take effect; when full, the pop frees no slot in that cycle.
REQ-026 A pop while empty with a simultaneous push SHALL be an underflow; the pushed symbol is stored.
REQ-027 sym_data SHALL be stable while sym_valid=1 and sym_ready=0 (source obligation; the block does not check it).
REQ-028 underflow_cnt SHALL saturate at 8'hFF and never wrap.
REQ-029 cur_sym SHALL change only on ui_tick or on entry to IDLE; the NCO SHALL use the new FCW from the cycle after the change, with phase continuous (no accumulator reset).

Reset
REQ-030 On rst=1 the block SHALL enter IDLE with ui_ph=0, nco_ph=0, DATA=0, ui_tick=0, cur_sym=01, underflow=0, underflow_cnt=0 and the FIFO empty; sym_ready=1 in the first cycle after reset.
REQ-031 rst SHALL override en and a push in the same cycle.

Configuration
REQ-032 With PAM4_TX_PRBS_EN defined, RUN symbols SHALL come from an internal PRBS7 (x^7+x^6+1, seed 7'h7F, advanced 2 bits per ui_tick, MSB first); sym_ready SHALL be held 0, sym_valid ignored, and underflow never asserted.
REQ-033 With PAM4_TX_PRBS_EN undefined, symbols SHALL come from the FIFO path as specified above.

Structure
REQ-034 Package pam4_tx_pkg SHALL hold the FCW constants, the symbol-code constants and the state enum.
REQ-035 The FIFO SHALL be a separate sub-module, pam4_sym_fifo (DEPTH, W=2), with push, pop, full, empty and dout.

Verification
REQ-036 Reset then en=1: ui_tick every 2 clk; the first 256 cur_sym values are 00,11,... alternating; DATA toggle rate alternates 10/25 MHz.
REQ-037 Push 00,01,10,11 in RUN: cur_sym follows in order at successive ui_tick; DATA periods are 5, 3.33 (avg), 2.5 and 2 clk.
REQ-038 Empty FIFO in RUN for 300 UIs: underflow pulses on each ui_tick, cur_sym=01, underflow_cnt=FF and stays FF.
REQ-039 Fill FIFO to 4 with sym_valid held high: sym_ready=0; a pop in the same cycle as a push attempt leaves the push rejected; the next cycle accepts it.
REQ-040 Drop en mid-RUN with 2 symbols queued: next cycle DATA=0 and state IDLE; on re-enable, the preamble repeats, then the 2 queued symbols are sent.
REQ-041 With PAM4_TX_PRBS_EN defined: the RUN symbol sequence matches the PRBS7 reference model for 127 UIs, and sym_ready=0 throughout.
